// File: rtl/uart_rx_tx_only_pkg.sv
// Shared definitions for the 8N1 UART core: frame parameters, FSM state
// encoding and the transmit line-level helper.
package uart_rx_tx_only_pkg;

  localparam int DBIT_DEF       = 8;   // data bits per frame
  localparam int SB_TICK_DEF    = 16;  // oversampling ticks per stop bit
  localparam int TIMER_BITS_DEF = 11;  // baud divisor width
  localparam int OVERSAMPLE     = 16;  // ticks per start/data bit
  localparam int START_MID      = 7;   // tick index of the start-bit centre

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Serial line level the transmitter drives while in a given state
  function automatic logic tx_line_level(input uart_state_e st, input logic data_bit);
    logic lvl;
    case (st)
      ST_IDLE:  lvl = 1'b1;
      ST_START: lvl = 1'b0;
      ST_DATA:  lvl = data_bit;
      ST_STOP:  lvl = 1'b1;
      default:  lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_rx_tx_only_baud_tick.sv
// Shared 16x oversampling tick: mod-(N+1) counter, one-clk pulse at each wrap.
// The divisor is compared on every clock, so a new value takes effect at the
// next wrap; a divisor lowered below the running count wraps immediately.
module uart_baud_tick
  import uart_rx_tx_only_pkg::*;
#(
  parameter int TIMER_BITS = TIMER_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TIMER_BITS-1:0] i_final_value,
  output logic                  o_tick
);

  localparam logic [TIMER_BITS-1:0] CNT_ONE = TIMER_BITS'(1);

  logic [TIMER_BITS-1:0] r_count;
  logic                  r_tick;

  // Divisor counter with a registered tick so nothing pulses during reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (r_count >= i_final_value) begin
      r_count <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + CNT_ONE;
      r_tick  <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx_tx_only.sv
// Full-duplex 8N1 UART: transmitter and receiver FSMs sharing one 16x tick.
// Line output and done pulses are registered; next values are derived from
// the next state so tx changes on the same edge as the state register.
module uart_rx_tx_only
  import uart_rx_tx_only_pkg::*;
#(
  parameter int DBIT       = DBIT_DEF,
  parameter int SB_TICK    = SB_TICK_DEF,
  parameter int TIMER_BITS = TIMER_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,            // active-high despite the name
  input  logic [DBIT-1:0]       tx_din,
  input  logic                  tx_start,
  output logic                  tx_done_tick,
  output logic                  tx,
  input  logic                  rx,
  output logic                  rx_done_tick,
  output logic [DBIT-1:0]       rx_dout,
  input  logic [TIMER_BITS-1:0] timer_final_value
);

  localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = $clog2(DBIT);

  localparam logic [S_W-1:0] OS_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
  localparam logic [S_W-1:0] S_MID   = S_W'(START_MID);
  localparam logic [S_W-1:0] S_ONE   = S_W'(1);
  localparam logic [N_W-1:0] N_LAST  = N_W'(DBIT - 1);
  localparam logic [N_W-1:0] N_ONE   = N_W'(1);

  logic w_s_tick;

  uart_baud_tick #(
    .TIMER_BITS (TIMER_BITS)
  ) u_baud (
    .clk           (clk),
    .rst           (reset_n),
    .i_final_value (timer_final_value),
    .o_tick        (w_s_tick)
  );

  // ---------------------------------------------------------------- TX
  uart_state_e     r_tx_state, w_tx_state_nx;
  logic [S_W-1:0]  r_tx_s,     w_tx_s_nx;
  logic [N_W-1:0]  r_tx_n,     w_tx_n_nx;
  logic [DBIT-1:0] r_tx_b,     w_tx_b_nx;
  logic            r_tx_line,  w_tx_line_nx;
  logic            r_tx_done,  w_tx_done_nx;

  // TX state, counters, shift register and registered line/done outputs
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_tx_state <= ST_IDLE;
      r_tx_s     <= '0;
      r_tx_n     <= '0;
      r_tx_b     <= '0;
      r_tx_line  <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_s     <= w_tx_s_nx;
      r_tx_n     <= w_tx_n_nx;
      r_tx_b     <= w_tx_b_nx;
      r_tx_line  <= w_tx_line_nx;
      r_tx_done  <= w_tx_done_nx;
    end
  end

  // TX next-state: start, LSB-first data, stop, done pulse on leaving stop
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_s_nx     = r_tx_s;
    w_tx_n_nx     = r_tx_n;
    w_tx_b_nx     = r_tx_b;
    w_tx_done_nx  = 1'b0;
    case (r_tx_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_tx_state_nx = ST_START;
          w_tx_s_nx     = '0;
          w_tx_b_nx     = tx_din;
        end else begin
          w_tx_state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_s_tick) begin
          if (r_tx_s == OS_LAST) begin
            w_tx_state_nx = ST_DATA;
            w_tx_s_nx     = '0;
            w_tx_n_nx     = '0;
          end else begin
            w_tx_s_nx = r_tx_s + S_ONE;
          end
        end else begin
          w_tx_s_nx = r_tx_s;
        end
      end
      ST_DATA: begin
        if (w_s_tick) begin
          if (r_tx_s == OS_LAST) begin
            w_tx_s_nx = '0;
            w_tx_b_nx = r_tx_b >> 1;
            if (r_tx_n == N_LAST) begin
              w_tx_state_nx = ST_STOP;
            end else begin
              w_tx_n_nx = r_tx_n + N_ONE;
            end
          end else begin
            w_tx_s_nx = r_tx_s + S_ONE;
          end
        end else begin
          w_tx_s_nx = r_tx_s;
        end
      end
      ST_STOP: begin
        if (w_s_tick) begin
          if (r_tx_s == SB_LAST) begin
            w_tx_state_nx = ST_IDLE;
            w_tx_done_nx  = 1'b1;
          end else begin
            w_tx_s_nx = r_tx_s + S_ONE;
          end
        end else begin
          w_tx_s_nx = r_tx_s;
        end
      end
      default: begin
        w_tx_state_nx = ST_IDLE;
      end
    endcase
    w_tx_line_nx = tx_line_level(w_tx_state_nx, w_tx_b_nx[0]);
  end

  assign tx           = r_tx_line;
  assign tx_done_tick = r_tx_done;

  // ---------------------------------------------------------------- RX
  logic r_rx_meta;
  logic r_rx_sync;

  // Two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  uart_state_e     r_rx_state, w_rx_state_nx;
  logic [S_W-1:0]  r_rx_s,     w_rx_s_nx;
  logic [N_W-1:0]  r_rx_n,     w_rx_n_nx;
  logic [DBIT-1:0] r_rx_b,     w_rx_b_nx;
  logic [DBIT-1:0] r_rx_dout,  w_rx_dout_nx;
  logic            r_rx_done,  w_rx_done_nx;

  // RX state, counters, shift register and registered byte/done outputs
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_rx_state <= ST_IDLE;
      r_rx_s     <= '0;
      r_rx_n     <= '0;
      r_rx_b     <= '0;
      r_rx_dout  <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_rx_s     <= w_rx_s_nx;
      r_rx_n     <= w_rx_n_nx;
      r_rx_b     <= w_rx_b_nx;
      r_rx_dout  <= w_rx_dout_nx;
      r_rx_done  <= w_rx_done_nx;
    end
  end

  // RX next-state: start-centre glitch check, mid-bit sampling, stop copy-out
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_s_nx     = r_rx_s;
    w_rx_n_nx     = r_rx_n;
    w_rx_b_nx     = r_rx_b;
    w_rx_dout_nx  = r_rx_dout;
    w_rx_done_nx  = 1'b0;
    case (r_rx_state)
      ST_IDLE: begin
        if (!r_rx_sync) begin
          w_rx_state_nx = ST_START;
          w_rx_s_nx     = '0;
        end else begin
          w_rx_state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_s_tick) begin
          if (r_rx_s == S_MID) begin
            if (!r_rx_sync) begin
              w_rx_state_nx = ST_DATA;
              w_rx_s_nx     = '0;
              w_rx_n_nx     = '0;
            end else begin
              w_rx_state_nx = ST_IDLE;  // line recovered: treat as noise
            end
          end else begin
            w_rx_s_nx = r_rx_s + S_ONE;
          end
        end else begin
          w_rx_s_nx = r_rx_s;
        end
      end
      ST_DATA: begin
        if (w_s_tick) begin
          if (r_rx_s == OS_LAST) begin
            w_rx_s_nx = '0;
            w_rx_b_nx = {r_rx_sync, r_rx_b[DBIT-1:1]};
            if (r_rx_n == N_LAST) begin
              w_rx_state_nx = ST_STOP;
            end else begin
              w_rx_n_nx = r_rx_n + N_ONE;
            end
          end else begin
            w_rx_s_nx = r_rx_s + S_ONE;
          end
        end else begin
          w_rx_s_nx = r_rx_s;
        end
      end
      ST_STOP: begin
        if (w_s_tick) begin
          if (r_rx_s == SB_LAST) begin
            // Stop-bit level is not inspected; the byte is delivered as-is
            w_rx_state_nx = ST_IDLE;
            w_rx_dout_nx  = r_rx_b;
            w_rx_done_nx  = 1'b1;
          end else begin
            w_rx_s_nx = r_rx_s + S_ONE;
          end
        end else begin
          w_rx_s_nx = r_rx_s;
        end
      end
      default: begin
        w_rx_state_nx = ST_IDLE;
      end
    endcase
  end

  assign rx_dout      = r_rx_dout;
  assign rx_done_tick = r_rx_done;

endmodule

// File: tb/tb_uart_rx_tx_only.sv
// Self-checking bench for uart_rx_tx_only: loopback round-trips with random
// bytes and divisors, start-glitch rejection, back-to-back frame timing and
// mid-frame reset. Expected bytes come from a queue scoreboard; expected
// timings come from frame arithmetic (10 bits x 16 ticks x (divisor+1)).
module tb_uart_rx_tx_only;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  tx_din;
  logic        tx_start;
  logic        tx_done_tick;
  logic        tx;
  logic        rx_line;
  logic        rx_done_tick;
  logic [7:0]  rx_dout;
  logic [10:0] tfv;
  logic        loop_en;
  logic        rx_drv;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  int tx_wide = 0;
  int rx_wide = 0;
  logic tx_done_q = 1'b0;
  logic rx_done_q = 1'b0;
  logic [7:0] exp_q[$];

  assign rx_line = loop_en ? tx : rx_drv;

  uart_rx_tx_only dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .tx_din            (tx_din),
    .tx_start          (tx_start),
    .tx_done_tick      (tx_done_tick),
    .tx                (tx),
    .rx                (rx_line),
    .rx_done_tick      (rx_done_tick),
    .rx_dout           (rx_dout),
    .timer_final_value (tfv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulse counting, pulse-width tracking and receive scoreboard
  always @(negedge clk) begin
    tx_done_q <= tx_done_tick;
    rx_done_q <= rx_done_tick;
    if (tx_done_tick) tx_done_cnt <= tx_done_cnt + 1;
    if (tx_done_tick && tx_done_q) tx_wide <= tx_wide + 1;
    if (rx_done_tick && rx_done_q) rx_wide <= rx_wide + 1;
    if (rx_done_tick) begin
      rx_done_cnt <= rx_done_cnt + 1;
      chk("rx_byte_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("rx_dout", rx_dout, exp_q.pop_front());
    end
  end

  task automatic wait_lvl(input logic lvl, input int budget, output int t, output logic ok);
    int n;
    n = 0;
    while (tx !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (tx === lvl);
    t  = cyc;
  endtask

  task automatic wait_done(input int want_tx, input int want_rx, input int budget, output logic ok);
    int n;
    n = 0;
    while ((tx_done_cnt < want_tx || rx_done_cnt < want_rx) && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (tx_done_cnt >= want_tx) && (rx_done_cnt >= want_rx);
  endtask

  // One loopback frame: send b, expect it back, expect exactly one tx_done
  task automatic xfer(input logic [7:0] b);
    int   base_tx, base_rx, budget;
    logic ok;
    budget  = 12 * 16 * (int'(tfv) + 1) + 100;
    base_tx = tx_done_cnt;
    base_rx = rx_done_cnt;
    exp_q.push_back(b);
    @(negedge clk);
    tx_din   = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_din   = 8'($urandom);   // must not disturb the frame in flight
    wait_done(base_tx + 1, base_rx + 1, budget, ok);
    chk("xfer_completes", ok, 1'b1);
    repeat (4) @(negedge clk);
    chk("tx_done_once", tx_done_cnt - base_tx, 1);
  endtask

  initial begin
    int   t1, t2, tr, tf, base_tx, base_rx;
    logic ok;
    logic [7:0] fixed_bytes [3];
    fixed_bytes[0] = 8'h00;
    fixed_bytes[1] = 8'hFF;
    fixed_bytes[2] = 8'hA5;

    reset_n  = 1'b1;
    tx_start = 1'b0;
    tx_din   = 8'h00;
    tfv      = 11'd53;
    loop_en  = 1'b1;
    rx_drv   = 1'b1;

    // Reset values
    #50;
    chk("rst_tx", tx, 1'b1);
    chk("rst_tx_done", tx_done_tick, 1'b0);
    chk("rst_rx_done", rx_done_tick, 1'b0);
    chk("rst_rx_dout", rx_dout, 8'h00);
    #50;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Loopback at the nominal divisor
    xfer(8'h7E);

    // Boundary bytes at a fast divisor, then random bytes and divisors
    tfv = 11'd3;
    foreach (fixed_bytes[i]) xfer(fixed_bytes[i]);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tfv = 11'($urandom_range(0, 7));
      xfer(8'($urandom));
    end

    // Start glitch: 3 ticks low must not produce a byte
    @(negedge clk);
    tfv     = 11'd3;
    repeat (8) @(negedge clk);
    loop_en = 1'b0;
    base_rx = rx_done_cnt;
    rx_drv  = 1'b0;
    repeat (3 * 4) @(negedge clk);
    rx_drv  = 1'b1;
    repeat (1400) @(negedge clk);
    chk("glitch_no_rx", rx_done_cnt - base_rx, 0);
    loop_en = 1'b1;
    xfer(8'h3C);

    // Reset during data bit 4 of a frame of zeros
    base_tx = tx_done_cnt;
    @(negedge clk);
    tx_din   = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5 * 64 + 31) @(negedge clk);
    chk("tx_low_mid_frame", tx, 1'b0);
    #2;
    reset_n = 1'b1;
    #1;
    chk("tx_rst_immediate", tx, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tx_held_in_rst", tx, 1'b1);
      chk("no_done_in_rst", {tx_done_tick, rx_done_tick}, 2'b00);
    end
    reset_n = 1'b0;
    repeat (1400) @(negedge clk);
    chk("rst_no_tx_done", tx_done_cnt - base_tx, 0);
    xfer(8'hC3);

    // Back-to-back frames at the nominal divisor, tx_start held high
    @(negedge clk);
    tfv = 11'd53;
    repeat (60) @(negedge clk);
    base_tx = tx_done_cnt;
    base_rx = rx_done_cnt;
    repeat (3) exp_q.push_back(8'h55);
    tx_din   = 8'h55;
    tx_start = 1'b1;
    wait_done(base_tx + 1, 0, 9500, ok);
    chk("b2b_frame1_done", ok, 1'b1);
    wait_lvl(1'b0, 10, t1, ok);
    chk("b2b_frame2_start", ok, 1'b1);
    wait_done(base_tx + 2, 0, 9500, ok);
    chk("b2b_frame2_done", ok, 1'b1);
    wait_lvl(1'b0, 10, t2, ok);
    chk("b2b_frame3_start", ok, 1'b1);
    tx_start = 1'b0;
    chk("b2b_period", t2 - t1, 10 * 16 * 54);
    wait_lvl(1'b1, 2000, tr, ok);
    chk("b2b_bit0_rise", ok, 1'b1);
    wait_lvl(1'b0, 2000, tf, ok);
    chk("b2b_bit1_fall", ok, 1'b1);
    chk("b2b_bit_width", tf - tr, 16 * 54);
    wait_done(base_tx + 3, base_rx + 3, 9500, ok);
    chk("b2b_all_done", ok, 1'b1);
    repeat (4) @(negedge clk);
    chk("b2b_tx_done_count", tx_done_cnt - base_tx, 3);

    // Global pulse and scoreboard checks
    chk("tx_done_one_clk", tx_wide, 0);
    chk("rx_done_one_clk", rx_wide, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
